wb_register_file: RTL and testbench
===================================

// Module: wb_register_file
// PURPOSE
//  Consumer end of the write-back interface: general-purpose register file that
//  accepts WriteData/WriteReg/RegWrite from the WB stage and serves two read
//  ports to the ID stage. Holds a per-register pending-write scoreboard: ID marks
//  a destination busy at issue, WB clears it at write-back, and ID gets a stall.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  ADDR_WIDTH  5   register index width; NREGS = 2**ADDR_WIDTH
//  BYPASS      1   1: same-cycle write forwarded to read ports; 0: read old value
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           asynchronous reset, active-low
//  RegWrite    in   1           write enable from WB stage
//  WriteReg    in   ADDR_WIDTH  write destination index
//  WriteData   in   DATA_WIDTH  write data
//  ReadReg1    in   ADDR_WIDTH  read port 1 index (rs)
//  ReadReg2    in   ADDR_WIDTH  read port 2 index (rt)
//  ReadData1   out  DATA_WIDTH  read port 1 data
//  ReadData2   out  DATA_WIDTH  read port 2 data
//  IssueValid  in   1           ID issues an instruction that will write IssueReg
//  IssueReg    in   ADDR_WIDTH  destination of issued instruction
//  Busy1       out  1           ReadReg1 has a pending write
//  Busy2       out  1           ReadReg2 has a pending write
//  Stall       out  1           Busy1 | Busy2
// BEHAVIOUR
//  - rst low (async): all registers <= 0, all busy bits <= 0 immediately; reads
//    then return 0, Busy1/Busy2/Stall = 0. Release is sampled on next clk edge.
//  - Register 0: hardwired 0; writes ignored; never marked busy; reads always 0.
//  - Write: on rising clk with RegWrite=1 and WriteReg!=0, regs[WriteReg] <=
//    WriteData. Visible on ReadDataN the following cycle (BYPASS=0) or the same
//    cycle combinationally (BYPASS=1, RegWrite=1, WriteReg==ReadRegN!=0).
//  - Reads: combinational, zero latency; both ports may address same register.
//  - Scoreboard (one bit per register, updated on rising clk):
//      IssueValid & IssueReg!=0         -> busy[IssueReg] <= 1
//      RegWrite & WriteReg!=0           -> busy[WriteReg] <= 0
//      both, same index                 -> set wins (newer producer pending)
//      both, different indices          -> both updates applied
//  - BusyN = busy[ReadRegN] & ~(BYPASS & RegWrite & WriteReg==ReadRegN): with
//    bypass, a register completing this cycle is not reported busy.
//  - Stall is purely combinational from busy bits and ports; no stall memory.
//  - RegWrite to a non-busy register is legal (writes data, busy stays 0).
//  - Reset mid-operation discards all pending writes; no write completes in the
//    cycle rst is low, even if RegWrite=1.
//  - No X propagation: all outputs defined for every input combination.
// TESTING
//  1 Reset: preload regs, pulse rst low mid-cycle -> ReadData1/2=0, Stall=0
//    before the next clk edge.
//  2 Write/read: write R5=0xDEADBEEF, next cycle ReadReg1=5 -> ReadData1=
//    0xDEADBEEF; write R0=0x1234 -> ReadData of R0 stays 0.
//  3 Bypass: BYPASS=1, RegWrite=1 WriteReg=7 WriteData=0xA5A5A5A5, ReadReg2=7
//    same cycle -> ReadData2=0xA5A5A5A5; BYPASS=0 -> previous R7 value.
//  4 Hazard: IssueValid R3, next cycle ReadReg1=3 -> Busy1=1, Stall=1; WB writes
//    R3 -> Stall drops same cycle (BYPASS=1) / next cycle (BYPASS=0).
//  5 Collision: IssueValid R9 and RegWrite R9 same edge -> busy[9]=1 after edge,
//    R9 holds new data; IssueReg=0 -> never busy, Stall=0.
//  6 Dual port: ReadReg1=ReadReg2=12 after write 0x0000_00FF -> both outputs
//    0x0000_00FF; random write/issue stream checked against reference model.

Source files
------------

// File: rtl/wb_register_file.sv
// Write-back side register file with two combinational read ports and a
// per-register pending-write scoreboard that drives the ID-stage stall.
module wb_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RegWrite,
   input  logic [ADDR_WIDTH-1:0] WriteReg,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [ADDR_WIDTH-1:0] ReadReg1,
   input  logic [ADDR_WIDTH-1:0] ReadReg2,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   input  logic                  IssueValid,
   input  logic [ADDR_WIDTH-1:0] IssueReg,
   output logic                  Busy1,
   output logic                  Busy2,
   output logic                  Stall
);

   localparam int NREGS     = 1 << ADDR_WIDTH;
   localparam bit BYPASS_EN = (BYPASS != 0);

   logic [DATA_WIDTH-1:0] regs [NREGS];
   logic [NREGS-1:0]      busy;
   logic [NREGS-1:0]      busy_next;
   logic                  write_en;
   logic                  issue_en;
   logic                  hit1;
   logic                  hit2;

   // A write to register 0 is dropped; the forwarding path is also gated by
   // reset so nothing leaks onto the read ports while rst is held low.
   assign write_en = RegWrite && (WriteReg != '0);
   assign issue_en = IssueValid && (IssueReg != '0);
   assign hit1     = BYPASS_EN && rst && write_en && (WriteReg == ReadReg1);
   assign hit2     = BYPASS_EN && rst && write_en && (WriteReg == ReadReg2);

   // Register storage; register 0 is never written so it stays at its reset zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[WriteReg] <= WriteData;
      end
   end

   // Scoreboard next state: completion clears first so a same-index issue,
   // being the newer producer, leaves the register marked pending.
   always_comb begin
      busy_next = busy;
      if (write_en) begin
         busy_next[WriteReg] = 1'b0;
      end
      if (issue_en) begin
         busy_next[IssueReg] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Scoreboard register; reset discards every pending write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Read ports, with the in-flight write forwarded when bypassing is enabled.
   always_comb begin
      ReadData1 = regs[ReadReg1];
      ReadData2 = regs[ReadReg2];
      if (hit1) begin
         ReadData1 = WriteData;
      end
      if (hit2) begin
         ReadData2 = WriteData;
      end
   end

   // Hazard outputs; a register completing this cycle through the bypass is
   // already usable and so is not reported busy.
   always_comb begin
      Busy1 = busy[ReadReg1] && !hit1;
      Busy2 = busy[ReadReg2] && !hit2;
      Stall = Busy1 || Busy2;
   end

endmodule

// File: tb/tb_wb_register_file.sv
// Directed and randomised checks of wb_register_file, run on a bypassing and
// a non-bypassing instance driven by the same stimulus.
module tb_wb_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic        IssueValid;
   logic [4:0]  IssueReg;

   logic [31:0] readData1B1, readData2B1, readData1B0, readData2B0;
   logic        busy1B1, busy2B1, stallB1, busy1B0, busy2B0, stallB0;

   logic [31:0] modelRegs [32];
   logic        modelBusy [32];

   int checkCount = 0;
   int errorCount = 0;

   wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dutB1 (
      .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
      .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .ReadData1(readData1B1), .ReadData2(readData2B1),
      .IssueValid(IssueValid), .IssueReg(IssueReg),
      .Busy1(busy1B1), .Busy2(busy2B1), .Stall(stallB1)
   );

   wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dutB0 (
      .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
      .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .ReadData1(readData1B0), .ReadData2(readData2B0),
      .IssueValid(IssueValid), .IssueReg(IssueReg),
      .Busy1(busy1B0), .Busy2(busy2B0), .Stall(stallB0)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rw, input logic [4:0] wr,
                                input logic [31:0] wd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic iv,
                                input logic [4:0] ir);
      RegWrite   = rw;
      WriteReg   = wr;
      WriteData  = wd;
      ReadReg1   = r1;
      ReadReg2   = r2;
      IssueValid = iv;
      IssueReg   = ir;
      #1;
   endtask

   task automatic clearModel();
      for (int i = 0; i < 32; i++) begin
         modelRegs[i] = '0;
         modelBusy[i] = 1'b0;
      end
   endtask

   // Update the reference model with the current inputs, then cross the edge.
   task automatic tick();
      if (rst) begin
         if (RegWrite && WriteReg != 5'd0) begin
            modelRegs[WriteReg] = WriteData;
            modelBusy[WriteReg] = 1'b0;
         end
         if (IssueValid && IssueReg != 5'd0) begin
            modelBusy[IssueReg] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] expRead(input logic [4:0] addr, input bit byp);
      if (!rst || addr == 5'd0) return 32'd0;
      if (byp && RegWrite && WriteReg == addr) return WriteData;
      return modelRegs[addr];
   endfunction

   function automatic logic expBusy(input logic [4:0] addr, input bit byp);
      if (!rst) return 1'b0;
      if (byp && RegWrite && WriteReg == addr && addr != 5'd0) return 1'b0;
      return modelBusy[addr];
   endfunction

   task automatic compareAll();
      logic e1, e2;
      checkOutput("rand_rd1_b1", readData1B1, expRead(ReadReg1, 1'b1));
      checkOutput("rand_rd2_b1", readData2B1, expRead(ReadReg2, 1'b1));
      checkOutput("rand_rd1_b0", readData1B0, expRead(ReadReg1, 1'b0));
      checkOutput("rand_rd2_b0", readData2B0, expRead(ReadReg2, 1'b0));
      e1 = expBusy(ReadReg1, 1'b1);
      e2 = expBusy(ReadReg2, 1'b1);
      checkOutput("rand_busy1_b1", 32'(busy1B1), 32'(e1));
      checkOutput("rand_busy2_b1", 32'(busy2B1), 32'(e2));
      checkOutput("rand_stall_b1", 32'(stallB1), 32'(e1 | e2));
      e1 = expBusy(ReadReg1, 1'b0);
      e2 = expBusy(ReadReg2, 1'b0);
      checkOutput("rand_busy1_b0", 32'(busy1B0), 32'(e1));
      checkOutput("rand_busy2_b0", 32'(busy2B0), 32'(e2));
      checkOutput("rand_stall_b0", 32'(stallB0), 32'(e1 | e2));
   endtask

   initial begin
      clearModel();
      rst = 1'b0;
      // Reset held: a pending bypass write must not reach the read ports.
      applyStimulus(1'b1, 5'd1, 32'hCAFE_F00D, 5'd1, 5'd1, 1'b1, 5'd1);
      checkOutput("reset_rd1_b1", readData1B1, 32'h0);
      checkOutput("reset_stall_b1", 32'(stallB1), 32'h0);
      tick();
      rst = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b0, 5'd0);
      checkOutput("after_reset_rd1_b0", readData1B0, 32'h0);

      // Plain write then read; register 0 ignores writes.
      applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
      checkOutput("wr_r5_rd1_b1", readData1B1, 32'hDEAD_BEEF);
      checkOutput("wr_r5_rd1_b0", readData1B0, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, 1'b0, 5'd0);
      checkOutput("wr_r0_same_b1", readData1B1, 32'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
      checkOutput("wr_r0_rd1_b1", readData1B1, 32'h0);
      checkOutput("wr_r0_rd2_b0", readData2B0, 32'h0);

      // Bypass versus old value on port 2.
      applyStimulus(1'b1, 5'd7, 32'h7777_7777, 5'd0, 5'd0, 1'b0, 5'd0);
      tick();
      applyStimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd0, 5'd7, 1'b0, 5'd0);
      checkOutput("bypass_rd2_b1", readData2B1, 32'hA5A5_A5A5);
      checkOutput("bypass_rd2_b0", readData2B0, 32'h7777_7777);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0);
      checkOutput("bypass_next_rd2_b0", readData2B0, 32'hA5A5_A5A5);

      // Hazard on R3: busy after issue, released by write-back.
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
      checkOutput("hazard_busy1_b1", 32'(busy1B1), 32'h1);
      checkOutput("hazard_stall_b1", 32'(stallB1), 32'h1);
      checkOutput("hazard_stall_b0", 32'(stallB0), 32'h1);
      applyStimulus(1'b1, 5'd3, 32'h0000_0033, 5'd3, 5'd0, 1'b0, 5'd0);
      checkOutput("wb_same_stall_b1", 32'(stallB1), 32'h0);
      checkOutput("wb_same_stall_b0", 32'(stallB0), 32'h1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
      checkOutput("wb_next_stall_b0", 32'(stallB0), 32'h0);
      checkOutput("wb_next_busy1_b0", 32'(busy1B0), 32'h0);
      checkOutput("wb_next_rd1_b0", readData1B0, 32'h0000_0033);

      // Issue and write-back collide on R9: set wins, data still lands.
      applyStimulus(1'b1, 5'd9, 32'h9999_9999, 5'd0, 5'd0, 1'b1, 5'd9);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
      checkOutput("collide_busy1_b0", 32'(busy1B0), 32'h1);
      checkOutput("collide_busy1_b1", 32'(busy1B1), 32'h1);
      checkOutput("collide_rd1_b0", readData1B0, 32'h9999_9999);
      applyStimulus(1'b1, 5'd9, 32'h9999_9999, 5'd0, 5'd0, 1'b1, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0);
      checkOutput("issue_r0_stall_b1", 32'(stallB1), 32'h0);
      checkOutput("issue_r0_stall_b0", 32'(stallB0), 32'h0);

      // Both ports on the same register.
      applyStimulus(1'b1, 5'd12, 32'h0000_00FF, 5'd0, 5'd0, 1'b0, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 1'b0, 5'd0);
      checkOutput("dual_rd1_b1", readData1B1, 32'h0000_00FF);
      checkOutput("dual_rd2_b1", readData2B1, 32'h0000_00FF);
      checkOutput("dual_rd2_b0", readData2B0, 32'h0000_00FF);

      // Mid-cycle reset with a pending write and a busy register.
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4);
      tick();
      applyStimulus(1'b1, 5'd12, 32'h0000_0BAD, 5'd12, 5'd4, 1'b0, 5'd0);
      checkOutput("pre_reset_busy2_b0", 32'(busy2B0), 32'h1);
      rst = 1'b0;
      clearModel();
      #1;
      checkOutput("mid_reset_rd1_b1", readData1B1, 32'h0);
      checkOutput("mid_reset_rd1_b0", readData1B0, 32'h0);
      checkOutput("mid_reset_stall_b1", 32'(stallB1), 32'h0);
      checkOutput("mid_reset_stall_b0", 32'(stallB0), 32'h0);
      tick();
      rst = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd5, 1'b0, 5'd0);
      checkOutput("post_reset_rd1_b0", readData1B0, 32'h0);
      checkOutput("post_reset_rd2_b1", readData2B1, 32'h0);

      // Random write/issue stream over a small index range to force collisions.
      for (int cyc = 0; cyc < 300; cyc++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       $urandom, 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 7)));
         compareAll();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
